note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 The block SHALL have parameter BASE_FREQ, default 110<<20 (Q12.20 Hz), the root pitch that all tone ratios multiply.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, the note-event buffer depth (power of two).
REQ-003 The block SHALL have parameter VOLUME, default 419430 (0.4 in Q12.20), the level driven on both volume outputs while a note sounds.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  reset; synchronous and active-low.
REQ-006 sample_tick  in  1  one-cycle strobe per audio sample; note durations count these.
REQ-007 note_valid  in  1  producer offers a note event.
REQ-008 note_ready  out  1  high when the FIFO can accept an event this cycle.
REQ-009 note_tone  in  4  semitone index 0..12; 13..15 mean rest.
REQ-010 note_len  in  16  duration in sample_ticks.
REQ-011 frequency  out  32  Q12.20 oscillator frequency for the synthesizer.
REQ-012 saw_volume / square_volume  out  32 each  Q12.20 levels.
REQ-013 gate  out  1  high while a pitched note is sounding.
REQ-014 busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-015 An event SHALL be written when note_valid && note_ready; note_ready = !full, independent of a same-cycle pop.
REQ-016 FSM states SHALL be IDLE, LOAD, PLAY.
REQ-017 IDLE -> LOAD when the FIFO is non-empty; otherwise remain in IDLE with gate=0, volumes=0, and frequency held.
REQ-018 LOAD SHALL pop one event, compute frequency = (BASE_FREQ * RATIO[tone]) >> 20 using a 64-bit product truncated to 32 bits, load the counter with note_len, and go to PLAY.
REQ-019 In PLAY, gate=1 and both volumes=VOLUME for tone 0..12; for a rest, gate=0, volumes=0, and frequency is unchanged.
REQ-020 In PLAY, each sample_tick SHALL decrement the counter; when the decrement reaches 0, go to LOAD if the FIFO is non-empty, else IDLE.
REQ-021 note_len=0 SHALL skip the event: LOAD returns to LOAD or IDLE with no PLAY cycle and no gate pulse.
REQ-022 Latency: with an empty FIFO in IDLE, the outputs SHALL reflect a new note 3 clk after the accepting edge (FIFO write, IDLE->LOAD, LOAD->PLAY).
REQ-023 Back-to-back notes SHALL have one LOAD cycle between them, during which gate and the outputs hold the previous note's values.
REQ-024 A sample_tick during LOAD or IDLE SHALL be ignored.
REQ-025 The FIFO SHALL use wrap-around pointers with an extra MSB for full/empty detection.
REQ-026 A write when full SHALL be impossible, because note_ready is low.

Reset
REQ-027 With reset_n=0 at a clk edge, all of the following SHALL hold: state=IDLE, FIFO emptied, counter=0, frequency=0, volumes=0, gate=0, busy=0, note_ready=1 from the next cycle.
REQ-028 Reset mid-PLAY SHALL abort the note immediately and discard all queued events.

Structure
REQ-029 Package synth_pkg SHALL hold the Q12.20 constants (FRAC_BITS=20), the state enum, and RATIO[0:12].
REQ-030 Each RATIO entry SHALL equal floor(n*2^20/d) for 1/1, 16/15, 9/8, 6/5, 5/4, 4/3, 45/32, 3/2, 8/5, 5/3, 16/9, 15/8, 2/1.
REQ-031 The buffer SHALL be the sub-module note_fifo (width 20, depth FIFO_DEPTH); the FSM, multiplier and counter SHALL be in note_sequencer.

Verification
REQ-032 Push tone 7, len 3, then 3 ticks -> frequency=173015040, gate=1 for exactly 3 ticks, then IDLE with busy=0.
REQ-033 Push tone 0, tone 12, and tone 3, each len 2 -> frequency sequence 115343360, 230686720, 138412010, each with one LOAD cycle between.
REQ-034 Push 17 events with no ticks -> note_ready=0 after 16 are stored; the 17th is accepted only after the first pop.
REQ-035 Push tone 14, len 4 -> gate=0 and volumes=0 for 4 ticks, with frequency unchanged.
REQ-036 Push len=0 followed by tone 7, len 1 -> no gate pulse for the first event; the second event plays normally.
REQ-037 Assert reset_n=0 during PLAY with 5 events queued -> next cycle shows all outputs 0 and busy=0, and no queued note plays afterwards.

Source files
------------

// File: rtl/synth_pkg.sv
// synth_pkg: shared Q12.20 constants, sequencer state encoding and the
// just-intonation tone ratio table used by note_sequencer.
package synth_pkg;

  localparam int unsigned FRAC_BITS = 20;
  localparam int unsigned QWIDTH    = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPlay
  } seq_state_e;

  // floor(n * 2^20 / d) for the thirteen intervals of the octave.
  localparam logic [31:0] RATIO [0:12] = '{
    32'd1048576,  // 1/1
    32'd1118481,  // 16/15
    32'd1179648,  // 9/8
    32'd1258291,  // 6/5
    32'd1310720,  // 5/4
    32'd1398101,  // 4/3
    32'd1474560,  // 45/32
    32'd1572864,  // 3/2
    32'd1677721,  // 8/5
    32'd1747626,  // 5/3
    32'd1864135,  // 16/9
    32'd1966080,  // 15/8
    32'd2097152   // 2/1
  };

  // Tones 13..15 are rests and have no ratio.
  function automatic logic [31:0] tone_ratio(input logic [3:0] tone);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i <= 12; i++) begin
      if (tone == 4'(i)) r = RATIO[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: valid/ready note-event channel.
//   note_valid  producer offers an event
//   note_ready  consumer can accept an event this cycle
//   note_tone   semitone index 0..12, 13..15 = rest
//   note_len    duration in sample ticks
interface note_sequencer_if;
  logic        note_valid;
  logic        note_ready;
  logic [3:0]  note_tone;
  logic [15:0] note_len;

  modport master (
    output note_valid,
    output note_tone,
    output note_len,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_tone,
    input  note_len,
    output note_ready
  );
endinterface

// File: rtl/note_fifo.sv
// note_fifo: synchronous FIFO with wrap-around pointers carrying an extra MSB
// to tell full from empty.
//   clk, reset_n        clock, synchronous active-low reset (empties the FIFO)
//   wr_en, wr_data      write request (ignored when full)
//   rd_en, rd_data      pop request (ignored when empty); rd_data shows the head
//   full, empty, count  occupancy status
module note_fifo #(
  parameter int unsigned Width = 20,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AddrW:0]   count
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: buffers note events and plays them one after another,
// driving oscillator frequency, volumes and gate for a synthesizer voice.
//   clk, reset_n      clock, synchronous active-low reset
//   sample_tick       one strobe per audio sample; note lengths count these
//   note (slave)      note_valid/note_ready/note_tone/note_len event channel
//   frequency         Q12.20 oscillator frequency
//   saw_volume,
//   square_volume     Q12.20 levels, VOLUME while a pitched note sounds
//   gate              high while a pitched note sounds
//   busy              events queued or a note in progress
module note_sequencer
  import synth_pkg::*;
#(
  parameter int unsigned BASE_FREQ  = 110 << 20,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned VOLUME     = 419430
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_tick,
  note_sequencer_if.slave       note,
  output logic [QWIDTH-1:0]     frequency,
  output logic [QWIDTH-1:0]     saw_volume,
  output logic [QWIDTH-1:0]     square_volume,
  output logic                  gate,
  output logic                  busy
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

  seq_state_e        state_q;
  logic [15:0]       counter_q;
  logic [QWIDTH-1:0] frequency_q, volume_q;
  logic              gate_q;

  logic              fifo_full, fifo_empty, pop;
  logic [AddrW:0]    fifo_count;
  logic [19:0]       head;
  logic [3:0]        head_tone;
  logic [15:0]       head_len;
  logic              head_pitched;
  logic [QWIDTH-1:0] head_freq;

  note_fifo #(
    .Width (20),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (note.note_valid),
    .wr_data ({note.note_tone, note.note_len}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign note.note_ready = !fifo_full;
  assign pop             = (state_q == StLoad);
  assign head_tone       = head[19:16];
  assign head_len        = head[15:0];
  assign head_pitched    = (head_tone <= 4'd12);
  assign head_freq       = QWIDTH'((64'(BASE_FREQ) * 64'(tone_ratio(head_tone))) >> FRAC_BITS);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      counter_q   <= '0;
      frequency_q <= '0;
      volume_q    <= '0;
      gate_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          gate_q   <= 1'b0;
          volume_q <= '0;
          if (!fifo_empty) state_q <= StLoad;
        end
        StLoad: begin
          if (head_len == 16'd0) begin
            // Skipped event: keep loading while more remain after this pop.
            if (fifo_count > (AddrW+1)'(1)) begin
              state_q <= StLoad;
            end else begin
              state_q  <= StIdle;
              gate_q   <= 1'b0;
              volume_q <= '0;
            end
          end else begin
            state_q   <= StPlay;
            counter_q <= head_len;
            if (head_pitched) begin
              frequency_q <= head_freq;
              gate_q      <= 1'b1;
              volume_q    <= QWIDTH'(VOLUME);
            end else begin
              gate_q   <= 1'b0;
              volume_q <= '0;
            end
          end
        end
        StPlay: begin
          if (sample_tick) begin
            counter_q <= counter_q - 16'd1;
            if (counter_q == 16'd1) begin
              if (!fifo_empty) begin
                // Outputs hold the finished note through the LOAD cycle.
                state_q <= StLoad;
              end else begin
                state_q  <= StIdle;
                gate_q   <= 1'b0;
                volume_q <= '0;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign frequency     = frequency_q;
  assign saw_volume    = volume_q;
  assign square_volume = volume_q;
  assign gate          = gate_q;
  assign busy          = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

  localparam int unsigned BASE = 110 << 20;
  localparam int unsigned VOL  = 419430;
  localparam int unsigned RN [13] = '{1, 16, 9, 6, 5, 4, 45, 3, 8, 5, 16, 15, 2};
  localparam int unsigned RD [13] = '{1, 15, 8, 5, 4, 3, 32, 2, 5, 3, 9, 8, 1};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_tick;
  logic [31:0] frequency, saw_volume, square_volume;
  logic        gate, busy;

  note_sequencer_if nif ();

  note_sequencer #(
    .BASE_FREQ  (BASE),
    .FIFO_DEPTH (16),
    .VOLUME     (VOL)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_tick   (sample_tick),
    .note          (nif),
    .frequency     (frequency),
    .saw_volume    (saw_volume),
    .square_volume (square_volume),
    .gate          (gate),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] cur_freq;
  logic [64:0] exp_q [$];  // {gate, frequency, volume} expected at each tick

  function automatic logic [31:0] exp_freq(input int tone);
    longint unsigned r, p;
    r = (longint'(RN[tone]) << 20) / longint'(RD[tone]);
    p = longint'(BASE) * r;
    return p[51:20];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic push(input logic [3:0] t, input logic [15:0] l);
    int w;
    w = 0;
    while (!nif.note_ready && w < 50) begin
      step();
      w++;
    end
    if (w == 50) begin
      total++;
      bad++;
      $error("FAIL push_timeout: observed=not_ready expected=ready");
    end
    nif.note_valid = 1'b1;
    nif.note_tone  = t;
    nif.note_len   = l;
    step();
    nif.note_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic g, input logic [31:0] f,
                         input logic [31:0] v);
    chk({tag, "_gate"}, 32'(gate), 32'(g));
    chk({tag, "_freq"}, frequency, f);
    chk({tag, "_saw"}, saw_volume, v);
    chk({tag, "_sq"}, square_volume, v);
  endtask

  initial begin
    int n, accepted, gated, t, l;
    logic [64:0] e;

    reset_n = 1'b0;
    sample_tick = 1'b0;
    nif.note_valid = 1'b0;
    nif.note_tone = '0;
    nif.note_len = '0;
    step();
    step();
    reset_n = 1'b1;
    chk_out("reset", 1'b0, 32'd0, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(nif.note_ready), 32'd1);

    // Single note, with ticks held high through IDLE and LOAD (ignored there).
    sample_tick = 1'b1;
    push(4'd7, 16'd3);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_gate_a", 32'(gate), 32'd0);
    step();
    chk("s1_gate_b", 32'(gate), 32'd0);
    step();
    sample_tick = 1'b0;
    chk_out("s1_play", 1'b1, 32'd173015040, VOL);
    tick();
    chk("s1_t1_gate", 32'(gate), 32'd1);
    tick();
    chk("s1_t2_gate", 32'(gate), 32'd1);
    tick();
    chk_out("s1_end", 1'b0, 32'd173015040, 32'd0);
    chk("s1_end_busy", 32'(busy), 32'd0);

    // Back-to-back notes with a held LOAD cycle between them.
    push(4'd0, 16'd2);
    push(4'd12, 16'd2);
    push(4'd3, 16'd2);
    chk_out("s2_n0", 1'b1, 32'd115343360, VOL);
    tick();
    tick();
    chk_out("s2_load0", 1'b1, 32'd115343360, VOL);
    step();
    chk_out("s2_n1", 1'b1, 32'd230686720, VOL);
    tick();
    tick();
    chk_out("s2_load1", 1'b1, 32'd230686720, VOL);
    step();
    chk_out("s2_n2", 1'b1, 32'd138412010, VOL);
    tick();
    tick();
    chk("s2_end_gate", 32'(gate), 32'd0);
    chk("s2_end_busy", 32'(busy), 32'd0);

    // Zero-length event is skipped without a gate pulse.
    push(4'd12, 16'd0);
    push(4'd7, 16'd1);
    chk("s5_gate_a", 32'(gate), 32'd0);
    step();
    chk_out("s5_skip", 1'b0, 32'd138412010, 32'd0);
    step();
    chk_out("s5_play", 1'b1, 32'd173015040, VOL);
    tick();
    chk("s5_end_gate", 32'(gate), 32'd0);
    chk("s5_end_busy", 32'(busy), 32'd0);

    // Rest: silent for its whole length, frequency untouched.
    push(4'd14, 16'd4);
    step();
    step();
    chk_out("s4_rest", 1'b0, 32'd173015040, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("s4_busy", 32'(busy), 32'd1);
      tick();
      chk_out("s4_tick", 1'b0, 32'd173015040, 32'd0);
    end
    chk("s4_end_busy", 32'(busy), 32'd0);

    // Random sequences checked against a per-tick expectation list.
    cur_freq = 32'd173015040;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(3, 8);
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        t = $urandom_range(0, 15);
        l = $urandom_range(1, 4);
        push(4'(t), 16'(l));
        if (t <= 12) cur_freq = exp_freq(t);
        for (int k = 0; k < l; k++) begin
          if (t <= 12) exp_q.push_back({1'b1, cur_freq, VOL});
          else exp_q.push_back({1'b0, cur_freq, 32'd0});
        end
      end
      step();
      step();
      step();
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_out("rnd", e[64], e[63:32], e[31:0]);
        tick();
        step();
        step();
        step();
      end
      chk("rnd_end_busy", 32'(busy), 32'd0);
      chk("rnd_end_gate", 32'(gate), 32'd0);
    end

    // Fill the FIFO while the first note plays with no ticks.
    accepted = 0;
    nif.note_valid = 1'b1;
    nif.note_len = 16'd1;
    for (int c = 0; c < 40 && accepted < 17; c++) begin
      nif.note_tone = 4'(accepted % 13);
      if (nif.note_ready) accepted++;
      step();
    end
    chk("s3_accepted", 32'(accepted), 32'd17);
    chk("s3_ready_full", 32'(nif.note_ready), 32'd0);
    repeat (3) step();  // valid stays high while full
    nif.note_valid = 1'b0;
    chk("s3_ready_held", 32'(nif.note_ready), 32'd0);
    tick();
    chk("s3_ready_before_pop", 32'(nif.note_ready), 32'd0);
    step();
    chk("s3_ready_after_pop", 32'(nif.note_ready), 32'd1);
    push(4'd5, 16'd1);
    chk("s3_ready_refull", 32'(nif.note_ready), 32'd0);
    gated = 0;
    for (int c = 0; c < 300 && busy; c++) begin
      if (gate) gated++;
      tick();
      step();
      step();
    end
    chk("s3_notes_played", 32'(gated), 32'd17);
    chk("s3_end_busy", 32'(busy), 32'd0);

    // Reset in the middle of a note with five more queued.
    for (int i = 0; i < 6; i++) push(4'd4, 16'd5);
    chk("s6_busy", 32'(busy), 32'd1);
    chk("s6_gate", 32'(gate), 32'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk_out("s6_reset", 1'b0, 32'd0, 32'd0);
    chk("s6_reset_busy", 32'(busy), 32'd0);
    chk("s6_reset_ready", 32'(nif.note_ready), 32'd1);
    gated = 0;
    for (int c = 0; c < 20; c++) begin
      if (gate || busy) gated++;
      tick();
      step();
    end
    chk("s6_no_replay", 32'(gated), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
